conv2d_stream: RTL
==================

# conv2d_stream

Parametrised streaming 2-D convolution engine: successor to the fixed 28×28 `conv` block. It accepts one signed pixel per handshake in raster order and applies a run-time-loadable K×K signed kernel plus bias, with stride 1 and no padding. It emits one result per valid window, with backpressure, optional ReLU and an end-of-frame flag. It sits between the image/feature-map source and the pooling/FC stages of the CNN datapath.

## Interface
- `IMG_W`, default 28: frame width in pixels (≥ K).
- `IMG_H`, default 28: frame height in pixels (≥ K).
- `K`, default 5: kernel side (2..7).
- `DW`, default 16: pixel and weight width, signed two's complement.
- `ACC_W`, default 32: accumulator and output width (≥ 2·DW).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `w_start`  in  1: pulse in IDLE to begin a kernel load.
- `w_valid`  in  1: weight beat valid, LOAD state only.
- `w_data`  in  DW: weight, raster order (row 0 col 0 first).
- `bias`  in  ACC_W: signed bias, sampled per result.
- `relu_en`  in  1: clamp negative results to 0.
- `in_valid`  in  1: pixel valid.
- `in_ready`  out  1: pixel accepted when `in_valid && in_ready`.
- `in_data`  in  DW: pixel.
- `out_valid`  out  1: result valid; held until accepted.
- `out_ready`  in  1: sink ready.
- `out_data`  out  ACC_W: result.
- `out_last`  out  1: with `out_valid`, marks the final result of the frame.
- `finish`  out  1: one-cycle pulse the cycle after the final result is accepted.
- `busy`  out  1: high in LOAD or RUN.

## Operation
- **States**
  - IDLE→LOAD on `w_start`.
  - LOAD→IDLE after K·K `w_valid` beats.
  - IDLE→RUN on the first accepted pixel.
  - RUN→IDLE when the final result is accepted.
  - `w_start` is ignored outside IDLE.
  - `w_valid` is ignored outside LOAD.
- **Storage**
  - Weights are held in a K×K register array.
  - K−1 line buffers of IMG_W entries feed a K×K window register.
- **Counters**
  - Column counter wraps IMG_W−1→0 and increments the row counter.
  - The row counter reaching IMG_H−1 with column IMG_W−1 marks end of input.
- **Window validity:** the window is valid when the accepted pixel has row ≥ K−1 and col ≥ K−1. This gives (IMG_H−K+1)·(IMG_W−K+1) results per frame.
- **Arithmetic**
  - Each DW×DW product is a full-precision signed 2·DW-bit value, sign-extended to ACC_W.
  - The sum of the K·K products plus `bias` wraps modulo 2^ACC_W (no saturation).
  - If `relu_en` is set and the MSB is 1, the result becomes 0.
- **Backpressure:** `in_ready` = (state≠LOAD) && (!`out_valid` || `out_ready`). Pixels are never dropped, and no pixel is accepted while a result is stalled.
- After `finish`, counters return to 0 and the weights are retained. The next frame may start the following cycle.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `finish`=0, `busy`=0.
- Reset also clears weights, line buffers, window and counters, and the state becomes IDLE.
- Latency: a result is registered on the edge that accepts its completing pixel, so `out_valid` rises 1 cycle later.
- `out_data` and `out_last` are stable while `out_valid && !out_ready`.
- A result is accepted and a new pixel is accepted in the same cycle when `out_ready`=1.
- `bias` and `relu_en` are sampled on the same edge as the completing pixel.
- Reset mid-frame or mid-load aborts immediately. The partial frame is discarded and weights read as 0 until reloaded.
- `w_start` in the same cycle as `in_valid` in IDLE: the load takes priority and the pixel is not accepted (`in_ready`=0 from the next cycle).

## Structure
- Shared package `conv_pkg`:
  - state enum (IDLE, LOAD, RUN);
  - derived constants `OUT_W`=IMG_W−K+1 and `OUT_H`=IMG_H−K+1;
  - counter width function (clog2).
- One sub-module, `conv_line_buffer`: parametrised IMG_W-deep, DW-wide delay line with a shift enable, instantiated K−1 times.
- The MAC sum is a combinational adder tree in the top level.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with random inputs. Required: all outputs at reset values, no `out_valid`.
- **Basic sum:** K=3, 4×4 frame, all weights 1, bias 0, pixels 1..16 with `out_ready`=1. Required: outputs 54, 63, 90, 99; `out_last` on 99; `finish` pulses one cycle later.
- **Backpressure:** same stimulus with `out_ready`=0 for 5 cycles after the first `out_valid`. Required: `out_data` holds 54, `in_ready`=0 during the stall, and the final sequence is identical.
- **Signed and ReLU:** weights −1, bias 10.
  - `relu_en`=0 gives 0xFFFFFFD4, 0xFFFFFFCB, 0xFFFFFFB0, 0xFFFFFFA7.
  - `relu_en`=1 gives four zeros.
- **Wrap:** K=3, all pixels and weights 0x7FFF, bias 0. Required: every output is 0x3FF70009 (32-bit wrap of 9·0x3FFF0001).
- **Mid-frame reset:** K=3, 4×4 frame, load weights 1; after 7 pixels assert `reset`, then release and send a full frame without reloading, with bias 5. Required: four outputs of 5. Reload weights 1 and resend pixels 1..16 with bias 0: outputs 54, 63, 90, 99.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and sizing helpers for the streaming convolution engine
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Bits needed to count 0..n-1 (never less than one bit)
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Number of valid window positions along one axis (stride 1, no padding)
  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - IMG_W-deep pixel delay line advanced once per accepted pixel
module conv_line_buffer #(
  parameter int IMG_W = 28,
  parameter int DW    = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] mem_q [IMG_W];

  // Shift the whole line by one entry per accepted pixel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < IMG_W; i++) mem_q[i] <= '0;
    end else if (en_i) begin
      mem_q[0] <= data_i;
      for (int i = 1; i < IMG_W; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign data_o = mem_q[IMG_W-1];

endmodule

// File: rtl/conv2d_stream.sv
// rtl/conv2d_stream.sv - streaming KxK signed convolution with bias, ReLU and backpressure
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5,
  parameter int DW    = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_start,
  input  logic             w_valid,
  input  logic [DW-1:0]    w_data,
  input  logic [ACC_W-1:0] bias,
  input  logic             relu_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic             finish,
  output logic             busy
);

  localparam int NW        = K * K;
  localparam int CW        = cnt_w(IMG_W);
  localparam int RW        = cnt_w(IMG_H);
  localparam int WCW       = cnt_w(NW);
  localparam int OUT_W     = out_dim(IMG_W, K);
  localparam int OUT_H     = out_dim(IMG_H, K);
  // First row/column at which a full window exists
  localparam int FIRST_COL = IMG_W - OUT_W;
  localparam int FIRST_ROW = IMG_H - OUT_H;

  state_e                  state_q, state_d;
  logic [WCW-1:0]          w_cnt_q, w_cnt_d;
  logic signed [DW-1:0]    w_q   [NW];
  logic signed [DW-1:0]    win_q [K][K];
  logic signed [DW-1:0]    win_d [K][K];
  logic signed [DW-1:0]    taps  [K];
  logic [DW-1:0]           lb_out [K-1];
  logic [CW-1:0]           col_q;
  logic [RW-1:0]           row_q;
  logic                    out_valid_q, out_last_q, finish_q;
  logic [ACC_W-1:0]        out_data_q;
  logic signed [ACC_W-1:0] sum;
  logic [ACC_W-1:0]        result;
  logic                    load_req, pix_acc, out_acc, last_pix, win_ok;

  assign in_ready = (state_q != ST_LOAD) && (!out_valid_q || out_ready);
  // A kernel-load request in IDLE wins over a pixel offered in the same cycle
  assign load_req = (state_q == ST_IDLE) && w_start;
  assign pix_acc  = in_valid && in_ready && !load_req;
  assign out_acc  = out_valid_q && out_ready;
  assign last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
  assign win_ok   = (row_q >= RW'(FIRST_ROW)) && (col_q >= CW'(FIRST_COL));

  // Tap 0 is the live pixel, tap j is the same column j rows earlier
  always_comb begin
    taps[0] = in_data;
    for (int j = 1; j < K; j++) taps[j] = lb_out[j-1];
  end

  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    conv_line_buffer #(.IMG_W(IMG_W), .DW(DW)) u_lb (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (pix_acc),
      .data_i (taps[g]),
      .data_o (lb_out[g])
    );
  end

  // Window as it will look after the current pixel shifts in (row 0 = oldest line)
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
      win_d[r][K-1] = taps[K-1-r];
    end
  end

  // Full-precision products sign-extended and summed with the bias, modulo 2^ACC_W
  always_comb begin
    logic signed [2*DW-1:0] ax, bx, prod;
    sum = bias;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        ax   = (2*DW)'(win_d[r][c]);
        bx   = (2*DW)'(w_q[r*K+c]);
        prod = ax * bx;
        sum  = sum + ACC_W'(prod);
      end
    end
    result = (relu_en && sum[ACC_W-1]) ? '0 : sum;
  end

  // Next-state logic: load sequencing and frame run/complete
  always_comb begin
    state_d = state_q;
    w_cnt_d = w_cnt_q;
    case (state_q)
      ST_IDLE: begin
        w_cnt_d = '0;
        if (w_start)      state_d = ST_LOAD;
        else if (pix_acc) state_d = ST_RUN;
      end
      ST_LOAD: begin
        if (w_valid) begin
          w_cnt_d = w_cnt_q + WCW'(1);
          if (w_cnt_q == WCW'(NW - 1)) begin
            w_cnt_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        // A pixel of the next frame accepted alongside the final result keeps us running
        if (out_acc && out_last_q && !pix_acc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and load counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      w_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      w_cnt_q <= w_cnt_d;
    end
  end

  // Kernel storage, written one beat at a time in raster order
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else if (state_q == ST_LOAD && w_valid) begin
      w_q[w_cnt_q] <= w_data;
    end
  end

  // Window register and raster position counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      col_q <= '0;
      row_q <= '0;
    end else if (pix_acc) begin
      win_q <= win_d;
      if (col_q == CW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= last_pix ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Output register: loaded on the completing pixel, held until the sink accepts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      finish_q <= out_acc && out_last_q;
      if (pix_acc && win_ok) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result;
        out_last_q  <= last_pix;
      end else if (out_acc) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign finish    = finish_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
